instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: prefetch buffer entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Reset  input  1: synchronous, active-high reset.
REQ-005 Address  output  32: word-aligned fetch address driven to InstructionMemory, equal to current PC.
REQ-006 Instruction  input  32: combinational read data from InstructionMemory for Address.
REQ-007 Redirect  input  1: branch/jump request; flush and restart fetch.
REQ-008 RedirectAddr  input  32: new fetch address, sampled when Redirect=1.
REQ-009 InstrValid  output  1: buffer head holds a valid instruction.
REQ-010 InstrReady  input  1: consumer accepts the head this cycle.
REQ-011 InstrOut  output  32: instruction word at buffer head.
REQ-012 InstrPC  output  32: fetch address of InstrOut.
REQ-013 FetchCount  output  32: accepted-instruction counter; present only under IFU_PERF_COUNT_EN.

Function
REQ-014 Address SHALL equal PC combinationally; Address[1:0] SHALL always be 2'b00.
REQ-015 Pop SHALL occur when InstrValid=1 and InstrReady=1 at a rising edge.
REQ-016 Push SHALL occur when Redirect=0 and (count<DEPTH or pop in same cycle); it stores {PC, Instruction} at tail and sets PC<=PC+4.
REQ-017 No push SHALL occur when full without a simultaneous pop; PC SHALL hold.
REQ-018 Simultaneous push and pop at full SHALL leave count unchanged.
REQ-019 InstrValid SHALL be count!=0 and Redirect=0; InstrOut/InstrPC SHALL come from registered buffer head.
REQ-020 Latency: instruction fetched at edge N SHALL be visible on InstrOut after edge N (one cycle).
REQ-021 Redirect=1 SHALL clear buffer (count<=0), set PC<={RedirectAddr[31:2],2'b00}, suppress push and pop that cycle.
REQ-022 PC SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0); no fault raised.
REQ-023 Buffer pointers SHALL wrap modulo DEPTH.

Reset
REQ-024 Reset=1 SHALL set PC<=RESET_PC, count/pointers<=0, FetchCount<=0; InstrValid=0 next cycle.
REQ-025 Reset SHALL dominate Redirect, push and pop; reset mid-stream discards all buffered entries.
REQ-026 InstrOut/InstrPC SHALL read 0 after reset until first push.

Configuration
REQ-027 Macro IFU_PERF_COUNT_EN defined: FetchCount port exists, increments by 1 per pop, wraps at 2^32, cleared by Reset only.
REQ-028 Macro undefined: FetchCount port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package ifu_pkg SHALL hold WORD_W=32, INSTR_BYTES=4, default RESET_PC, and buffer-entry type {pc, instr}.
REQ-030 Buffer SHALL be sub-module fetch_buffer (synchronous FIFO, push/pop/flush, count, DEPTH param); PC/control stays in top.

Verification (InstructionMemory preloaded: word index i holds i*3)
REQ-031 Reset 1 cycle, InstrReady=1 -> consecutive cycles InstrOut 0,3,6,9 with InstrPC 0,4,8,12.
REQ-032 InstrReady=0 for 10 cycles -> count saturates at 4 (PCs 0..12), Address holds 16; then InstrReady=1 -> InstrOut 0,3,6,9,12 on consecutive cycles, no gaps or duplicates.
REQ-033 Redirect=1, RedirectAddr=32'h43 with buffer non-empty -> InstrValid=0 that cycle, next InstrOut=48, InstrPC=32'h40, stale entries never appear.
REQ-034 Reset asserted mid-stream simultaneously with Redirect -> next InstrOut=0, InstrPC=RESET_PC.
REQ-035 Full buffer with InstrReady=1 continuously for 8 cycles -> count stays 4, one instruction per cycle in order.
REQ-036 IFU_PERF_COUNT_EN defined, 5 handshakes then 3 stall cycles -> FetchCount=5; Reset -> FetchCount=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   WORD_W, INSTR_BYTES : machine word width and instruction size in bytes
//   RESET_PC_DEFAULT    : default PC loaded on reset
//   ifu_entry_t         : prefetch buffer entry {pc, instr}
//   next_pc / align_word: sequential PC step and word alignment helpers
package ifu_pkg;
  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } ifu_entry_t;

  // Sequential fetch step; wraps modulo 2^32 by plain truncation.
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(INSTR_BYTES);
  endfunction

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO holding prefetched {pc, instr} entries.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   push       : write wr_entry at the tail
//   pop        : advance the head
//   flush      : discard all entries (overrides push/pop)
//   wr_entry   : entry to store
//   rd_entry   : registered head entry (zero until the first push after reset)
//   count      : number of valid entries, 0..DEPTH
module fetch_buffer
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  ifu_entry_t       wr_entry,
  output ifu_entry_t       rd_entry,
  output logic [CNT_W-1:0] count
);

  ifu_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             loaded;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      loaded <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        loaded <= 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; the head mux below hides it until something is written.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = loaded ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential instruction prefetcher with redirect.
// Optional feature macro: IFU_PERF_COUNT_EN adds the FetchCount output.
// Ports:
//   Clk, Reset   : clock and synchronous active-high reset
//   Address      : word-aligned fetch address (current PC) to instruction memory
//   Instruction  : combinational read data for Address
//   Redirect     : flush buffer and restart fetch at RedirectAddr
//   RedirectAddr : new fetch address (low two bits ignored)
//   InstrValid   : buffer head holds a valid instruction
//   InstrReady   : consumer accepts the head this cycle
//   InstrOut     : instruction at buffer head
//   InstrPC      : fetch address of InstrOut
//   FetchCount   : accepted-instruction counter (IFU_PERF_COUNT_EN only)
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] Instruction,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectAddr,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [WORD_W-1:0] InstrOut,
`ifdef IFU_PERF_COUNT_EN
  output logic [WORD_W-1:0] InstrPC,
  output logic [WORD_W-1:0] FetchCount
`else
  output logic [WORD_W-1:0] InstrPC
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              pop;
  logic              push;
  ifu_entry_t        wr_entry;
  ifu_entry_t        rd_entry;

  assign Address    = align_word(pc);
  assign full       = (count == CNT_W'(DEPTH));
  // A pending redirect hides the head so stale instructions never escape.
  assign InstrValid = (count != '0) && !Redirect;
  assign pop        = InstrValid && InstrReady;
  // At full, a same-cycle pop frees the slot the push lands in.
  assign push       = !Redirect && (!full || pop);

  assign wr_entry = '{pc: Address, instr: Instruction};
  assign InstrOut = rd_entry.instr;
  assign InstrPC  = rd_entry.pc;

  always_ff @(posedge Clk) begin
    if (Reset)         pc <= align_word(RESET_PC);
    else if (Redirect) pc <= align_word(RedirectAddr);
    else if (push)     pc <= next_pc(Address);
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_fetch_buffer (
    .clk     (Clk),
    .rst     (Reset),
    .push    (push),
    .pop     (pop),
    .flush   (Redirect),
    .wr_entry(wr_entry),
    .rd_entry(rd_entry),
    .count   (count)
  );

`ifdef IFU_PERF_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)    FetchCount <= '0;
    else if (pop) FetchCount <= FetchCount + WORD_W'(1);
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Redirect;
  logic        InstrReady;
  logic [31:0] RedirectAddr;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrValid;
`ifdef IFU_PERF_COUNT_EN
  logic [31:0] FetchCount;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of fetched words plus the architectural PC.
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  bit          m_loaded;

  always #5 Clk = ~Clk;

  // Instruction memory: word index i holds i*3.
  assign Instruction = (Address >> 2) * 32'd3;

  instruction_fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Address(Address),
    .Instruction(Instruction),
    .Redirect(Redirect),
    .RedirectAddr(RedirectAddr),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .InstrOut(InstrOut),
`ifdef IFU_PERF_COUNT_EN
    .InstrPC(InstrPC),
    .FetchCount(FetchCount)
`else
    .InstrPC(InstrPC)
`endif
  );

  // One clock: apply inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst, input bit redir, input bit rdy, input logic [31:0] raddr);
    bit exp_valid;
    bit do_pop;
    bit do_push;
    Reset = rst; Redirect = redir; InstrReady = rdy; RedirectAddr = raddr;
    #1;
    exp_valid = (q_pc.size() != 0) && !redir;
    checks++;
    if (InstrValid !== exp_valid) begin
      errors++; $display("FAIL valid t=%0t got %b want %b", $time, InstrValid, exp_valid);
    end
    checks++;
    if (Address !== m_pc) begin
      errors++; $display("FAIL address t=%0t got %h want %h", $time, Address, m_pc);
    end
    if (exp_valid) begin
      checks += 2;
      if (InstrOut !== q_ins[0]) begin
        errors++; $display("FAIL instr_out t=%0t got %h want %h", $time, InstrOut, q_ins[0]);
      end
      if (InstrPC !== q_pc[0]) begin
        errors++; $display("FAIL instr_pc t=%0t got %h want %h", $time, InstrPC, q_pc[0]);
      end
    end else if (!m_loaded) begin
      checks += 2;
      if (InstrOut !== 32'd0 || InstrPC !== 32'd0) begin
        errors++; $display("FAIL zero_head t=%0t got %h/%h want 0/0", $time, InstrOut, InstrPC);
      end
    end
`ifdef IFU_PERF_COUNT_EN
    checks++;
    if (FetchCount !== m_fc) begin
      errors++; $display("FAIL fetch_count t=%0t got %0d want %0d", $time, FetchCount, m_fc);
    end
`endif
    @(posedge Clk);
    if (rst) begin
      q_pc.delete(); q_ins.delete();
      m_pc = RESET_PC & ~32'd3; m_fc = 0; m_loaded = 0;
    end else if (redir) begin
      q_pc.delete(); q_ins.delete();
      m_pc = raddr & ~32'd3;
    end else begin
      do_pop  = (q_pc.size() != 0) && rdy;
      do_push = (q_pc.size() < DEPTH) || do_pop;
      if (do_pop) begin
        void'(q_pc.pop_front()); void'(q_ins.pop_front());
        m_fc = m_fc + 1;
      end
      if (do_push) begin
        q_pc.push_back(m_pc);
        q_ins.push_back((m_pc >> 2) * 32'd3);
        m_pc = m_pc + 32'd4;
        m_loaded = 1;
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1; Redirect = 0; InstrReady = 1; RedirectAddr = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    q_pc.delete(); q_ins.delete();
    m_pc = RESET_PC; m_fc = 0; m_loaded = 0;
    #1;
    checks += 4;
    if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", InstrValid); end
    if (InstrOut !== 32'd0) begin errors++; $display("FAIL reset_out got %h want 0", InstrOut); end
    if (InstrPC !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", InstrPC); end
    if (Address !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", Address, RESET_PC); end
  endtask

  task automatic test_stream();
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks += 3;
      if (InstrValid !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d got %b want 1", i, InstrValid); end
      if (InstrOut !== 32'(i * 3)) begin errors++; $display("FAIL stream_out i=%0d got %0d want %0d", i, InstrOut, i * 3); end
      if (InstrPC !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc i=%0d got %0d want %0d", i, InstrPC, i * 4); end
      cycle(0, 0, 1, 0);
    end
  endtask

  task automatic test_stall();
    cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    checks += 2;
    if (Address !== 32'd16) begin errors++; $display("FAIL stall_addr got %0d want 16", Address); end
    if (InstrValid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", InstrValid); end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0);
      // After each accepting edge the next in-order word is at the head.
      checks++;
      if (InstrOut !== 32'((i + 1) * 3)) begin
        errors++; $display("FAIL stall_drain i=%0d got %0d want %0d", i, InstrOut, (i + 1) * 3);
      end
    end
  endtask

  task automatic test_redirect();
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 32'h43);
    cycle(0, 0, 1, 0);
    checks += 3;
    if (InstrValid !== 1'b1) begin errors++; $display("FAIL redir_valid got %b want 1", InstrValid); end
    if (InstrOut !== 32'd48) begin errors++; $display("FAIL redir_out got %0d want 48", InstrOut); end
    if (InstrPC !== 32'h40) begin errors++; $display("FAIL redir_pc got %h want 40", InstrPC); end
  endtask

  task automatic test_reset_redirect();
    repeat (5) cycle(0, 0, 1, 0);
    cycle(1, 1, 1, 32'h100);
    cycle(0, 0, 1, 0);
    checks += 3;
    if (InstrValid !== 1'b1) begin errors++; $display("FAIL rstredir_valid got %b want 1", InstrValid); end
    if (InstrOut !== 32'd0) begin errors++; $display("FAIL rstredir_out got %0d want 0", InstrOut); end
    if (InstrPC !== RESET_PC) begin errors++; $display("FAIL rstredir_pc got %h want %h", InstrPC, RESET_PC); end
  endtask

  task automatic test_full_stream();
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (InstrValid !== 1'b1) begin errors++; $display("FAIL full_valid i=%0d got %b want 1", i, InstrValid); end
      if (InstrOut !== 32'(i * 3)) begin errors++; $display("FAIL full_out i=%0d got %0d want %0d", i, InstrOut, i * 3); end
      cycle(0, 0, 1, 0);
    end
    checks++;
    if (Address !== 32'd48) begin errors++; $display("FAIL full_addr got %0d want 48", Address); end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 32'hFFFF_FFF6);
    checks++;
    if (Address !== 32'hFFFF_FFF4) begin errors++; $display("FAIL wrap_redir got %h want fffffff4", Address); end
    repeat (3) cycle(0, 0, 0, 0);
    checks++;
    if (Address !== 32'd0) begin errors++; $display("FAIL wrap_addr got %h want 0", Address); end
    repeat (6) cycle(0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 400; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, addr);
    end
  endtask

`ifdef IFU_PERF_COUNT_EN
  task automatic test_perf();
    int guard;
    cycle(1, 0, 1, 0);
    guard = 0;
    while (m_fc < 5 && guard < 20) begin
      cycle(0, 0, 1, 0);
      guard++;
    end
    repeat (3) cycle(0, 0, 0, 0);
    checks++;
    if (FetchCount !== 32'd5) begin errors++; $display("FAIL perf_count got %0d want 5", FetchCount); end
    cycle(1, 0, 0, 0);
    checks++;
    if (FetchCount !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d want 0", FetchCount); end
  endtask
`endif

  initial begin
    @(negedge Clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_redirect();
    test_full_stream();
    test_wrap();
    test_random();
`ifdef IFU_PERF_COUNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
